// File: rtl/viterbi_block_decoder.sv
// Hard-decision rate-1/2 block Viterbi decoder.
// One frame in, ACS one pair per cycle, traceback, one result out.
module viterbi_block_decoder #(
    parameter int N = 8,
    parameter int K = 3,
    parameter logic [K-1:0] G0 = 3'b111,
    parameter logic [K-1:0] G1 = 3'b101,
    parameter bit TERMINATED = 1'b1,
    localparam int MW = $clog2(2*N+2)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2*N-1:0]  i_data,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [N-1:0]    o_data,
    output logic [MW-1:0]   o_metric
);

    localparam int S  = 1 << (K-1);
    localparam int SW = K - 1;
    localparam int TW = $clog2(N);
    localparam logic [MW-1:0] UNREACH = MW'(2*N+1);

    typedef enum logic [1:0] {IDLE, ACS, TRACE, OUT} state_t;

    state_t state_q, state_d;

    logic [2*N-1:0] data_q;
    logic [MW-1:0]  metric_q [S];
    logic [MW-1:0]  metric_d [S];
    logic [S-1:0]   dec;
    logic [S-1:0]   surv_q [N];
    logic [TW-1:0]  t_q;
    logic [TW-1:0]  bit_idx;
    logic [SW-1:0]  s_q;
    logic [SW-1:0]  start_s;
    logic [MW-1:0]  best_m;
    logic [1:0]     rx;

    function automatic logic [1:0] code_pair(input logic [K-1:0] r);
        return {^(r & G0), ^(r & G1)};
    endfunction

    function automatic logic [1:0] hamming(input logic [1:0] x);
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    function automatic logic [MW-1:0] sat_add(
        input logic [MW-1:0] a,
        input logic [1:0]    b
    );
        logic [MW:0] sum;
        sum = {1'b0, a} + {{(MW-1){1'b0}}, b};
        return sum[MW] ? {MW{1'b1}} : sum[MW-1:0];
    endfunction

    assign rx      = data_q[2*N-1 -: 2];
    assign bit_idx = TW'(N - 1) - t_q;
    assign i_ready = en && (state_q == IDLE);
    assign o_valid = (state_q == OUT);

    for (genvar g = 0; g < S; g++) begin : g_acs
        localparam logic [SW-1:0] P0 = SW'((2*g) % S);
        localparam logic [SW-1:0] P1 = SW'((2*g) % S + 1);
        localparam logic          U  = 1'(g >> (SW-1));
        logic [1:0]    bm0, bm1;
        logic [MW-1:0] c0, c1;
        assign bm0 = hamming(rx ^ code_pair({U, P0}));
        assign bm1 = hamming(rx ^ code_pair({U, P1}));
        assign c0  = sat_add(metric_q[P0], bm0);
        assign c1  = sat_add(metric_q[P1], bm1);
        assign dec[g]      = (c1 < c0);
        assign metric_d[g] = dec[g] ? c1 : c0;
    end

    // Traceback start: state 0, or lowest-index minimum-metric state
    always_comb begin
        start_s = '0;
        best_m  = metric_d[0];
        if (!TERMINATED) begin
            for (int i = 1; i < S; i++) begin
                if (metric_d[i] < best_m) begin
                    best_m  = metric_d[i];
                    start_s = SW'(i);
                end
            end
        end
    end

    // State register; en freezes the FSM
    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else if (en)
            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (i_valid) state_d = ACS;
            ACS:   if (t_q == TW'(N - 1)) state_d = TRACE;
            TRACE: if (t_q == '0) state_d = OUT;
            OUT:   if (o_ready) state_d = IDLE;
        endcase
    end

    // Frame latch, path metrics, step counter and traceback
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q   <= '0;
            t_q      <= '0;
            s_q      <= '0;
            o_data   <= '0;
            o_metric <= '0;
            for (int i = 0; i < S; i++)
                metric_q[i] <= '0;
        end else if (en) begin
            unique case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        data_q <= i_data;
                        t_q    <= '0;
                        for (int i = 0; i < S; i++)
                            metric_q[i] <= (i == 0) ? '0 : UNREACH;
                    end
                end
                ACS: begin
                    data_q <= data_q << 2;
                    for (int i = 0; i < S; i++)
                        metric_q[i] <= metric_d[i];
                    if (t_q == TW'(N - 1)) begin
                        s_q      <= start_s;
                        o_metric <= metric_d[start_s];
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                TRACE: begin
                    o_data[bit_idx] <= s_q[SW-1];
                    s_q <= {s_q[SW-2:0], surv_q[t_q][s_q]};
                    if (t_q != '0)
                        t_q <= t_q - TW'(1);
                end
                default: ;
            endcase
        end
    end

    // Survivor memory: one decision vector per trellis step
    always_ff @(posedge clk) begin
        if (en && state_q == ACS)
            surv_q[t_q] <= dec;
    end

endmodule

// File: tb/tb_viterbi_block_decoder.sv
// Bench for viterbi_block_decoder: directed vectors plus a
// register-exchange reference decoder checked every cycle.
module tb_viterbi_block_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        o_ready = 1'b1;
    logic        iv8 = 1'b0;
    logic [15:0] id8 = '0;
    logic        iv16 = 1'b0;
    logic [31:0] id16 = '0;

    logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
    logic [7:0]  od_a, od_b;
    logic [4:0]  om_a, om_b;
    logic [15:0] od_c;
    logic [5:0]  om_c;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    bit armed = 1'b0;

    viterbi_block_decoder #(.N(8), .K(3), .G0(3'b111), .G1(3'b101),
        .TERMINATED(1'b1)) dut_a (
        .clk(clk), .rst(rst), .en(en), .i_valid(iv8), .i_ready(ir_a),
        .i_data(id8), .o_valid(ov_a), .o_ready(o_ready),
        .o_data(od_a), .o_metric(om_a));

    viterbi_block_decoder #(.N(8), .K(3), .G0(3'b111), .G1(3'b101),
        .TERMINATED(1'b0)) dut_b (
        .clk(clk), .rst(rst), .en(en), .i_valid(iv8), .i_ready(ir_b),
        .i_data(id8), .o_valid(ov_b), .o_ready(o_ready),
        .o_data(od_b), .o_metric(om_b));

    viterbi_block_decoder #(.N(16), .K(4), .G0(4'b1101), .G1(4'b1111),
        .TERMINATED(1'b1)) dut_c (
        .clk(clk), .rst(rst), .en(en), .i_valid(iv16), .i_ready(ir_c),
        .i_data(id16), .o_valid(ov_c), .o_ready(o_ready),
        .o_data(od_c), .o_metric(om_c));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference encoder: first info bit is u[n-1], first pair at the top
    function automatic logic [127:0] encode(input int n, input int k,
        input int g0, input int g1, input logic [63:0] u);
        logic [127:0] c;
        int st;
        int ub;
        int x;
        c = '0;
        st = 0;
        for (int t = 0; t < n; t++) begin
            ub = int'(u[n-1-t]);
            x = (ub << (k-1)) | st;
            c[2*n-1-2*t] = ^(x & g0);
            c[2*n-2-2*t] = ^(x & g1);
            st = (ub << (k-2)) | (st >> 1);
        end
        return c;
    endfunction

    // Reference decoder: forward trellis with full path per state
    function automatic void decode(input int n, input int k, input int g0,
        input int g1, input int term, input logic [127:0] c,
        output logic [63:0] bits, output int met);
        int m [16];
        int nm [16];
        logic [63:0] p [16];
        logic [63:0] np [16];
        int ns_cnt;
        int lim;
        int r0, r1, x, ns, d, cand, start;
        ns_cnt = 1 << (k-1);
        lim = (1 << $clog2(2*n+2)) - 1;
        for (int s = 0; s < ns_cnt; s++) begin
            m[s] = (s == 0) ? 0 : 2*n + 1;
            p[s] = '0;
        end
        for (int t = 0; t < n; t++) begin
            r0 = int'(c[2*n-1-2*t]);
            r1 = int'(c[2*n-2-2*t]);
            for (int s = 0; s < ns_cnt; s++) begin
                nm[s] = -1;
                np[s] = '0;
            end
            for (int s = 0; s < ns_cnt; s++) begin
                for (int u = 0; u < 2; u++) begin
                    ns = (u << (k-2)) | (s >> 1);
                    x = (u << (k-1)) | s;
                    d = ((r0 != int'(^(x & g0))) ? 1 : 0)
                      + ((r1 != int'(^(x & g1))) ? 1 : 0);
                    cand = m[s] + d;
                    if (cand > lim) cand = lim;
                    if (nm[ns] < 0 || cand < nm[ns]) begin
                        nm[ns] = cand;
                        np[ns] = (p[s] << 1) | 64'(u);
                    end
                end
            end
            for (int s = 0; s < ns_cnt; s++) begin
                m[s] = nm[s];
                p[s] = np[s];
            end
        end
        start = 0;
        if (term == 0)
            for (int s = 1; s < ns_cnt; s++)
                if (m[s] < m[start]) start = s;
        bits = p[start] & ((64'(1) << n) - 64'(1));
        met = m[start];
    endfunction

    function automatic logic [127:0] gen(input int n, input int k,
        input int g0, input int g1);
        logic [63:0] u;
        logic [127:0] c;
        int ne;
        u = {$urandom, $urandom};
        u = u & ((64'(1) << n) - 64'(1));
        u = u & ~((64'(1) << (k-1)) - 64'(1));
        c = encode(n, k, g0, g1, u);
        ne = $urandom_range(0, 2);
        for (int e = 0; e < ne; e++)
            c[$urandom_range(0, 2*n-1)] ^= 1'b1;
        return c;
    endfunction

    // Scoreboard state per DUT
    string tag [3] = '{"a", "b", "c"};
    int nn [3] = '{8, 8, 16};
    int kk [3] = '{3, 3, 4};
    int g0s [3] = '{7, 7, 13};
    int g1s [3] = '{5, 5, 15};
    int tms [3] = '{1, 0, 1};
    bit busy [3] = '{0, 0, 0};
    int cnt [3] = '{0, 0, 0};
    logic [63:0] exp_d [3];
    int exp_m [3];
    logic vv [3];
    logic rr [3];
    logic ii [3];
    logic [63:0] od [3];
    logic [63:0] om [3];
    logic [127:0] dat [3];
    logic expv;

    // Compare every DUT against the reference each cycle
    always @(negedge clk) begin
        if (armed) begin
            vv[0] = ov_a; vv[1] = ov_b; vv[2] = ov_c;
            rr[0] = ir_a; rr[1] = ir_b; rr[2] = ir_c;
            ii[0] = iv8; ii[1] = iv8; ii[2] = iv16;
            od[0] = 64'(od_a); od[1] = 64'(od_b); od[2] = 64'(od_c);
            om[0] = 64'(om_a); om[1] = 64'(om_b); om[2] = 64'(om_c);
            dat[0] = 128'(id8); dat[1] = 128'(id8); dat[2] = 128'(id16);
            for (int d = 0; d < 3; d++) begin
                expv = busy[d] && (cnt[d] >= 2*nn[d]);
                check({"o_valid_", tag[d]}, 64'(vv[d]), 64'(expv));
                check({"i_ready_", tag[d]}, 64'(rr[d]),
                      64'(!busy[d] && en));
                if (expv) begin
                    check({"o_data_", tag[d]}, od[d], exp_d[d]);
                    check({"o_metric_", tag[d]}, om[d], 64'(exp_m[d]));
                end
                if (rst) begin
                    busy[d] = 1'b0;
                end else if (en) begin
                    if (busy[d]) begin
                        if (cnt[d] >= 2*nn[d]) begin
                            if (o_ready) busy[d] = 1'b0;
                        end else begin
                            cnt[d]++;
                        end
                    end else if (ii[d]) begin
                        busy[d] = 1'b1;
                        cnt[d] = 0;
                        decode(nn[d], kk[d], g0s[d], g1s[d], tms[d],
                               dat[d], exp_d[d], exp_m[d]);
                    end
                end
            end
        end
    end

    task automatic run8(input logic [15:0] d, output int lat,
        output logic [7:0] da, output int ma,
        output logic [7:0] db, output int mb);
        int w;
        lat = -1; da = '0; ma = -1; db = '0; mb = -1;
        @(posedge clk); #1;
        iv8 = 1'b1;
        id8 = d;
        w = 0;
        @(negedge clk);
        while (!(ir_a && en)) begin
            w++;
            if (w > 100) begin
                check("accept_timeout", 64'(0), 64'(1));
                iv8 = 1'b0;
                return;
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        id8 = ~d;
        lat = 0;
        @(negedge clk);
        while (!ov_a) begin
            lat++;
            if (lat > 100) begin
                check("valid_timeout", 64'(0), 64'(1));
                return;
            end
            @(negedge clk);
        end
        da = od_a; ma = int'(om_a);
        db = od_b; mb = int'(om_b);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] da, db;
        int ma, mb, lat, frames, prev, guard;
        bit acc;
        logic [127:0] tmp;
        logic [63:0] mbits;
        int mmet;

        tmp = encode(8, 3, 7, 5, 64'hB0);
        check("model_enc_b0", 64'(tmp[15:0]), 64'hE170);
        decode(8, 3, 7, 5, 1, 128'hE170, mbits, mmet);
        check("model_dec_clean", mbits, 64'hB0);
        check("model_met_clean", 64'(mmet), 64'd0);
        decode(8, 3, 7, 5, 1, 128'h6170, mbits, mmet);
        check("model_dec_err", mbits, 64'hB0);
        check("model_met_err", 64'(mmet), 64'd1);
        tmp = encode(16, 4, 13, 15, 64'hA5C0);
        decode(16, 4, 13, 15, 1, tmp, mbits, mmet);
        check("model_dec_k4", mbits, 64'hA5C0);

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        armed = 1'b1;
        @(negedge clk);
        check("rst_i_ready", 64'(ir_a), 64'd1);
        check("rst_o_valid", 64'(ov_a), 64'd0);
        check("rst_o_data", 64'(od_a), 64'd0);
        check("rst_o_metric", 64'(om_a), 64'd0);
        check("rst_o_data_c", 64'(od_c), 64'd0);

        run8(16'h0000, lat, da, ma, db, mb);
        check("zero_latency", 64'(lat), 64'd16);
        check("zero_data", 64'(da), 64'h00);
        check("zero_metric", 64'(ma), 64'd0);

        run8(16'hE170, lat, da, ma, db, mb);
        check("clean_data_t1", 64'(da), 64'hB0);
        check("clean_metric_t1", 64'(ma), 64'd0);
        check("clean_data_t0", 64'(db), 64'hB0);
        check("clean_metric_t0", 64'(mb), 64'd0);

        run8(16'h6170, lat, da, ma, db, mb);
        check("err15_data", 64'(da), 64'hB0);
        check("err15_metric", 64'(ma), 64'd1);

        for (int i = 0; i < 16; i++) begin
            run8(16'hE170 ^ (16'h1 << i), lat, da, ma, db, mb);
            check("flip_data", 64'(da), 64'hB0);
            check("flip_metric", 64'(ma), 64'd1);
        end

        @(posedge clk); #1;
        o_ready = 1'b0;
        run8(16'hE170, lat, da, ma, db, mb);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_o_valid", 64'(ov_a), 64'd1);
            check("bp_o_data", 64'(od_a), 64'hB0);
            check("bp_o_metric", 64'(om_a), 64'd0);
            check("bp_i_ready", 64'(ir_a), 64'd0);
        end
        @(posedge clk); #1;
        o_ready = 1'b1;

        fork
            run8(16'hE170, lat, da, ma, db, mb);
            begin
                repeat (3) @(posedge clk);
                #1 en = 1'b0;
                repeat (5) @(posedge clk);
                #1 en = 1'b1;
            end
        join
        check("stall_latency", 64'(lat), 64'd21);
        check("stall_data", 64'(da), 64'hB0);
        check("stall_metric", 64'(ma), 64'd0);

        @(posedge clk); #1;
        iv8 = 1'b1;
        id8 = 16'h0000;
        @(negedge clk);
        check("abort_accept", 64'(ir_a), 64'd1);
        @(posedge clk); #1;
        iv8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_i_ready", 64'(ir_a), 64'd1);
        check("abort_o_valid", 64'(ov_a), 64'd0);
        check("abort_o_data", 64'(od_a), 64'd0);
        check("abort_o_metric", 64'(om_a), 64'd0);
        run8(16'hE170, lat, da, ma, db, mb);
        check("after_abort_latency", 64'(lat), 64'd16);
        check("after_abort_data", 64'(da), 64'hB0);

        tmp = gen(8, 3, 7, 5);
        @(posedge clk); #1;
        id8 = tmp[15:0];
        iv8 = 1'b1;
        frames = 0;
        prev = -1;
        guard = 0;
        while (frames < 1024 && guard < 30000) begin
            @(negedge clk);
            acc = ir_a && iv8 && en;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                if (prev >= 0)
                    check("period8", 64'(cyc - prev), 64'd18);
                prev = cyc;
                frames++;
                tmp = gen(8, 3, 7, 5);
                id8 = tmp[15:0];
            end
        end
        iv8 = 1'b0;
        check("frames8", 64'(frames), 64'd1024);
        repeat (40) @(posedge clk);
        #1;

        tmp = gen(16, 4, 13, 15);
        id16 = tmp[31:0];
        iv16 = 1'b1;
        frames = 0;
        prev = -1;
        guard = 0;
        while (frames < 1024 && guard < 40000) begin
            @(negedge clk);
            acc = ir_c && iv16 && en;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                if (prev >= 0)
                    check("period16", 64'(cyc - prev), 64'd34);
                prev = cyc;
                frames++;
                tmp = gen(16, 4, 13, 15);
                id16 = tmp[31:0];
            end
        end
        iv16 = 1'b0;
        check("frames16", 64'(frames), 64'd1024);
        repeat (60) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
